alu_req_scheduler: RTL and testbench

//  Shares one ALU (A/B signed 32b, 3b opcode, 32b Result, Error) between NUM_REQ requesters.

---
 rtl/alu_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_req_scheduler.sv | 139 +++++++++++++
 tb/tb_alu_req_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and widths for the ALU request scheduler.
package alu_sched_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef logic [2:0] alu_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after ptr and wraps,
// so the requester at ptr (the last one served) has the lowest priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand_s;
  logic          found_s;
  logic          hit_s;

  // First requester found walking ptr+1, ptr+2, ... modulo N wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand_s  = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand_s      = IW'((int'(ptr) + i) % N);
      hit_s       = !found_s && req[cand_s];
      gnt[cand_s] = hit_s;
      gnt_idx     = hit_s ? cand_s : gnt_idx;
      found_s     = found_s | hit_s;
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one fixed-latency ALU between NUM_REQ requesters: round-robin grant,
// registered operand issue, result capture after ALU_LAT cycles, one-hot response.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*ALU_W-1:0] req_A,
  input  logic [NUM_REQ*ALU_W-1:0] req_B,
  input  logic [NUM_REQ*3-1:0]     req_opcode,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [ALU_W-1:0]         rsp_result,
  output logic                     rsp_error,
  output logic [ALU_W-1:0]         alu_A,
  output logic [ALU_W-1:0]         alu_B,
  output alu_op_t                  alu_opcode,
  input  logic [ALU_W-1:0]         alu_Result,
  input  logic                     alu_Error,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LAT_W = 4;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LAT - 1);

  sched_state_t       state_r;
  sched_state_t       state_s;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [NUM_REQ-1:0] owner_r;
  logic [LAT_W-1:0]   lat_cnt_r;
  logic               accept_s;

  logic [ALU_W-1:0]   a_arr_s  [NUM_REQ];
  logic [ALU_W-1:0]   b_arr_s  [NUM_REQ];
  alu_op_t            op_arr_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr_s[i]  = req_A[i*ALU_W +: ALU_W];
    assign b_arr_s[i]  = req_B[i*ALU_W +: ALU_W];
    assign op_arr_s[i] = req_opcode[i*3 +: 3];
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Grant is offered only while idle; held low for the whole of reset
  always_comb begin
    req_ready = '0;
    if (state_r == IDLE && !rst) begin
      req_ready = gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s = |(req_valid & req_ready);
  assign busy     = (state_r != IDLE);

  // Next-state logic for IDLE -> EXEC -> RESP -> IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = EXEC;
        else          state_s = IDLE;
      end
      EXEC: begin
        if (lat_cnt_r == '0) state_s = RESP;
        else                 state_s = EXEC;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Operand issue, latency count and response capture; rsp_valid pulses in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r   <= IDX_W'(NUM_REQ - 1);
      owner_r    <= '0;
      lat_cnt_r  <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_opcode <= 3'd0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_A      <= a_arr_s[gnt_idx_s];
            alu_B      <= b_arr_s[gnt_idx_s];
            alu_opcode <= op_arr_s[gnt_idx_s];
            owner_r    <= gnt_s;
            rr_ptr_r   <= gnt_idx_s;
            lat_cnt_r  <= LAT_INIT;
          end else begin
            lat_cnt_r  <= lat_cnt_r;
          end
        end
        EXEC: begin
          if (lat_cnt_r == '0) begin
            rsp_result <= alu_Result;
            rsp_error  <= alu_Error;
            rsp_valid  <= owner_r;
          end else begin
            lat_cnt_r  <= lat_cnt_r - 4'd1;
          end
        end
        default: begin
          lat_cnt_r <= lat_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench: dut0 runs with ALU_LAT=1, dut1 with ALU_LAT=3, each fed by
// a small behavioural ALU; a monitor pops expected responses as they appear.
module tb_alu_req_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]   req_valid  [2];
  logic [3:0]   req_ready  [2];
  logic [127:0] req_A      [2];
  logic [127:0] req_B      [2];
  logic [11:0]  req_opcode [2];
  logic [3:0]   rsp_valid  [2];
  logic [31:0]  rsp_result [2];
  logic         rsp_error  [2];
  logic [31:0]  alu_A      [2];
  logic [31:0]  alu_B      [2];
  logic [2:0]   alu_opcode [2];
  logic         busy       [2];
  logic [32:0]  alu_out    [2];

  typedef struct {
    int          d;
    int          g;
    logic [31:0] res;
    logic        err;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_a  [2];
  logic [31:0] last_b  [2];
  logic [2:0]  last_op [2];

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 sra, 7 illegal
  function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return {1'b0, a + b};
      3'd1:    return {1'b0, a - b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, a << b[4:0]};
      3'd6:    return {1'b0, 32'($signed(a) >>> b[4:0])};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  assign alu_out[0] = alu_f(alu_opcode[0], alu_A[0], alu_B[0]);
  assign alu_out[1] = alu_f(alu_opcode[1], alu_A[1], alu_B[1]);

  alu_req_scheduler #(.NUM_REQ(4), .ALU_LAT(1)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_A      (req_A[0]),
    .req_B      (req_B[0]),
    .req_opcode (req_opcode[0]),
    .rsp_valid  (rsp_valid[0]),
    .rsp_result (rsp_result[0]),
    .rsp_error  (rsp_error[0]),
    .alu_A      (alu_A[0]),
    .alu_B      (alu_B[0]),
    .alu_opcode (alu_opcode[0]),
    .alu_Result (alu_out[0][31:0]),
    .alu_Error  (alu_out[0][32]),
    .busy       (busy[0])
  );

  alu_req_scheduler #(.NUM_REQ(4), .ALU_LAT(3)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_A      (req_A[1]),
    .req_B      (req_B[1]),
    .req_opcode (req_opcode[1]),
    .rsp_valid  (rsp_valid[1]),
    .rsp_result (rsp_result[1]),
    .rsp_error  (rsp_error[1]),
    .alu_A      (alu_A[1]),
    .alu_B      (alu_B[1]),
    .alu_opcode (alu_opcode[1]),
    .alu_Result (alu_out[1][31:0]),
    .alu_Error  (alu_out[1][32]),
    .busy       (busy[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_last();
    for (int d = 0; d < 2; d++) begin
      last_a[d]  = 32'd0;
      last_b[d]  = 32'd0;
      last_op[d] = 3'd0;
    end
  endtask

  task automatic chk_reset_state();
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready",  32'(req_ready[d]),  32'd0);
      chk("rst_rsp_valid",  32'(rsp_valid[d]),  32'd0);
      chk("rst_rsp_result", rsp_result[d],      32'd0);
      chk("rst_rsp_error",  32'(rsp_error[d]),  32'd0);
      chk("rst_busy",       32'(busy[d]),       32'd0);
      chk("rst_alu_A",      alu_A[d],           32'd0);
      chk("rst_alu_B",      alu_B[d],           32'd0);
      chk("rst_alu_opcode", 32'(alu_opcode[d]), 32'd0);
    end
  endtask

  // Called at a negedge: asserts reset, checks outputs, releases two cycles later
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_reset_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_last();
  endtask

  // One transaction: present mask, expect grant g, then track EXEC/RESP
  task automatic run_op(input int d, input logic [3:0] mask, input int g, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                        input logic err, input bit abort);
    exp_t e;
    int   kmax;
    @(posedge clk);
    #1;
    req_valid[d] = mask;
    for (int i = 0; i < 4; i++) begin
      req_A[d][i*32 +: 32]     = (i == g) ? a  : 32'hA5A5_0000 + 32'(i);
      req_B[d][i*32 +: 32]     = (i == g) ? b  : 32'h5A5A_0000 + 32'(i);
      req_opcode[d][i*3 +: 3]  = (i == g) ? op : ~op;
    end
    @(negedge clk);
    chk("ready_grant",  32'(req_ready[d]),  32'd1 << g);
    chk("idle_busy",    32'(busy[d]),       32'd0);
    chk("idle_alu_A",   alu_A[d],           last_a[d]);
    chk("idle_alu_B",   alu_B[d],           last_b[d]);
    chk("idle_alu_op",  32'(alu_opcode[d]), 32'(last_op[d]));
    if (!abort) begin
      e.d = d; e.g = g; e.res = res; e.err = err; e.at = cyc + lat_of(d) + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      req_A[d][i*32 +: 32]    = 32'hBAD0_0000 + 32'(i);
      req_B[d][i*32 +: 32]    = 32'h0BAD_0000 + 32'(i);
      req_opcode[d][i*3 +: 3] = ~op;
    end
    kmax = abort ? 1 : lat_of(d) + 1;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      chk("busy_ready", 32'(req_ready[d]),  32'd0);
      chk("busy_flag",  32'(busy[d]),       32'd1);
      chk("hold_alu_A", alu_A[d],           a);
      chk("hold_alu_B", alu_B[d],           b);
      chk("hold_alu_op",32'(alu_opcode[d]), 32'(op));
    end
    if (abort) begin
      do_reset();
    end else begin
      last_a[d]  = a;
      last_b[d]  = b;
      last_op[d] = op;
    end
    req_valid[d] = 4'd0;
  endtask

  // Response monitor: every strobe must match the oldest expected entry
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] != 4'd0) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid[d]), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_dut",    32'(d),             32'(mon_e.d));
          chk("rsp_valid",  32'(rsp_valid[d]),  32'd1 << mon_e.g);
          chk("rsp_result", rsp_result[d],      mon_e.res);
          chk("rsp_error",  32'(rsp_error[d]),  32'(mon_e.err));
          chk("rsp_cycle",  32'(cyc),           32'(mon_e.at));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 4'd0;
      req_A[d]      = 128'd0;
      req_B[d]      = 128'd0;
      req_opcode[d] = 12'd0;
    end
    clear_last();
    @(negedge clk);
    do_reset();

    // Single add from requester 0
    run_op(0, 4'b0001, 0, 3'd0, 32'd7, -32'sd3, 32'd4, 1'b0, 1'b0);

    // All requesting from reset: strict 0,1,2,3 rotation
    @(negedge clk);
    do_reset();
    run_op(0, 4'b1111, 0, 3'd0, 32'd100,       32'd23,        32'd123,       1'b0, 1'b0);
    run_op(0, 4'b1111, 1, 3'd1, 32'd5,         32'd9,         32'hFFFF_FFFC, 1'b0, 1'b0);
    run_op(0, 4'b1111, 2, 3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0);
    run_op(0, 4'b1111, 3, 3'd3, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b0, 1'b0);
    run_op(0, 4'b1111, 0, 3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
    run_op(0, 4'b1111, 1, 3'd5, 32'h0000_0003, 32'd4,         32'h0000_0030, 1'b0, 1'b0);
    run_op(0, 4'b1111, 2, 3'd6, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0);
    run_op(0, 4'b1111, 3, 3'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1'b0);

    // Wrap after requester 2 is served
    run_op(0, 4'b0100, 2, 3'd1, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(0, 4'b0101, 0, 3'd0, -32'sd5,       -32'sd6,       32'hFFFF_FFF5, 1'b0, 1'b0);
    run_op(0, 4'b0101, 2, 3'd3, 32'd0,         32'd0,         32'd0,         1'b0, 1'b0);

    // Error passthrough, then a clean op
    run_op(0, 4'b1000, 3, 3'd7, 32'd1,         32'd2,         32'd0,         1'b1, 1'b0);
    run_op(0, 4'b1000, 3, 3'd0, 32'd2,         32'd2,         32'd4,         1'b0, 1'b0);
    run_op(0, 4'b0110, 1, 3'd1, 32'd10,        32'd3,         32'd7,         1'b0, 1'b0);

    // Three-cycle ALU
    run_op(1, 4'b0010, 1, 3'd1, -32'sd8,       32'd5,         32'hFFFF_FFF3, 1'b0, 1'b0);
    run_op(1, 4'b1111, 2, 3'd2, 32'h0F0F_00FF, 32'h00FF_0FF0, 32'h000F_00F0, 1'b0, 1'b0);
    run_op(1, 4'b1111, 3, 3'd7, 32'd3,         32'd4,         32'd0,         1'b1, 1'b0);

    // Reset in the middle of EXEC drops the op; requester 0 wins afterwards
    run_op(1, 4'b0100, 2, 3'd0, 32'd1,         32'd1,         32'd2,         1'b0, 1'b1);
    run_op(1, 4'b1111, 0, 3'd0, 32'd9,         32'd9,         32'd18,        1'b0, 1'b0);

    repeat (6) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
